pkt_bank_scheduler: RTL and testbench

//  Ping-pong packet bank controller between the network receive path and display_controller.
//  - Netstack streams payload bytes into the back bank.
//  - display_controller reads the front bank by address.
//  - Banks swap only on frame_sync, so a frame is never torn. Newest packet wins.
//  - Stale content is blanked after a programmable number of frames for laser safety.

---
 rtl/pkt_sched_pkg.sv | 14 +
 rtl/pkt_bank_ram.sv | 25 ++
 rtl/pkt_bank_scheduler.sv | 160 ++++++++++++++++
 tb/tb_pkt_bank_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_sched_pkg.sv
// rtl/pkt_sched_pkg.sv - shared types and sizes for the ping-pong packet bank scheduler
package pkt_sched_pkg;

   localparam int ETH_MTU   = 1500;
   localparam int PKT_DEPTH = ETH_MTU;

   typedef enum logic [1:0] {EMPTY, FILLING, READY, DISPLAYING} bank_state_t;
   typedef enum logic [1:0] {IDLE, FILL, DISCARD} wr_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pkt_bank_ram.sv
// rtl/pkt_bank_ram.sv - two-bank simple dual-port byte RAM, bank select is the address MSB
module pkt_bank_ram #(
   parameter int AW = 11
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW:0]   i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW:0]   i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [0:(2**(AW+1))-1];
   logic [7:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pkt_bank_scheduler.sv
// rtl/pkt_bank_scheduler.sv - ping-pong packet bank controller between netstack and display
module pkt_bank_scheduler
   import pkt_sched_pkg::*;
#(
   parameter int DEPTH        = PKT_DEPTH,
   parameter int AW           = 11,
   parameter int BLANK_FRAMES = 8
) (
   input  logic          sys_clk,
   input  logic          sys_rstn,
   input  logic [7:0]    wr_data,
   input  logic          wr_valid,
   input  logic          wr_last,
   output logic          wr_ready,
   input  logic          frame_sync,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic [15:0]   rd_len,
   output logic          rd_valid,
   output logic [15:0]   drop_count,
   output logic          err_oversize
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
   localparam logic [15:0] LP_BLANK = 16'(BLANK_FRAMES);

   wr_state_t   r_wr_st;
   bank_state_t r_bank_st [2];
   logic        r_front;
   logic [AW:0] r_wptr;
   logic [15:0] r_back_len;
   logic [15:0] r_blank_cnt;
   logic [15:0] r_rd_len;
   logic [15:0] r_drop_cnt;
   logic        r_rd_valid;
   logic        r_wr_ready;
   logic        r_err;
   logic        r_rd_hit;

   logic        w_back;
   logic        w_swap;
   logic        w_wbank;
   logic        w_start;
   logic        w_over;
   logic        w_super;
   logic        w_we;
   logic [AW:0] w_waddr;
   logic [7:0]  w_ram_q;
   logic [15:0] w_blank_nxt;

   assign w_back  = ~r_front;
   // A commit landing on the frame_sync cycle is not yet READY in r_bank_st, so it waits a frame.
   assign w_swap  = frame_sync && (r_bank_st[w_back] == READY);
   // A packet starting on a swap cycle must go to the bank that is becoming the back bank.
   assign w_wbank = w_swap ? r_front : w_back;
   assign w_start = (r_wr_st == IDLE) && wr_valid;
   assign w_over  = (r_wr_st == FILL) && wr_valid && (r_wptr == LP_DEPTH);
   assign w_super = w_start && !w_swap && (r_bank_st[w_back] == READY);
   assign w_we    = w_start || ((r_wr_st == FILL) && wr_valid && !w_over);
   assign w_waddr = {w_wbank, (w_start ? {AW{1'b0}} : r_wptr[AW-1:0])};
   assign w_blank_nxt = sat_inc16(r_blank_cnt);

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_wr_st      <= IDLE;
         r_bank_st[0] <= EMPTY;
         r_bank_st[1] <= EMPTY;
         r_front      <= 1'b0;
         r_wptr       <= '0;
         r_back_len   <= '0;
      end else begin
         if (w_swap) begin
            r_front            <= w_back;
            r_bank_st[w_back]  <= DISPLAYING;
            r_bank_st[r_front] <= EMPTY;
         end
         case (r_wr_st)
            IDLE: begin
               if (wr_valid) begin
                  r_wptr <= (AW+1)'(1);
                  if (wr_last) begin
                     r_back_len         <= 16'd1;
                     r_bank_st[w_wbank] <= READY;
                  end else begin
                     r_bank_st[w_wbank] <= FILLING;
                     r_wr_st            <= FILL;
                  end
               end
            end
            FILL: begin
               if (wr_valid) begin
                  if (w_over) begin
                     r_bank_st[w_wbank] <= EMPTY;
                     r_wr_st            <= wr_last ? IDLE : DISCARD;
                  end else if (wr_last) begin
                     r_back_len         <= 16'(r_wptr) + 16'd1;
                     r_bank_st[w_wbank] <= READY;
                     r_wr_st            <= IDLE;
                  end else begin
                     r_wptr <= r_wptr + (AW+1)'(1);
                  end
               end
            end
            DISCARD: begin
               if (wr_valid && wr_last) begin
                  r_wr_st <= IDLE;
               end
            end
            default: r_wr_st <= IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         r_rd_len    <= '0;
         r_rd_valid  <= 1'b0;
         r_blank_cnt <= '0;
         r_drop_cnt  <= '0;
         r_err       <= 1'b0;
         r_wr_ready  <= 1'b0;
         r_rd_hit    <= 1'b0;
      end else begin
         r_wr_ready <= 1'b1;
         r_err      <= w_over;
         if (w_over || w_super) begin
            r_drop_cnt <= sat_inc16(r_drop_cnt);
         end
         if (w_swap) begin
            r_rd_len    <= r_back_len;
            r_rd_valid  <= 1'b1;
            r_blank_cnt <= '0;
         end else if (frame_sync) begin
            r_blank_cnt <= w_blank_nxt;
            if ((BLANK_FRAMES != 0) && (w_blank_nxt >= LP_BLANK)) begin
               r_rd_valid <= 1'b0;
            end
         end
         // Mask is registered alongside the RAM read so data and mask refer to the same cycle.
         r_rd_hit <= r_rd_valid && (16'(rd_addr) < r_rd_len);
      end
   end

   pkt_bank_ram #(.AW(AW)) u_ram (
      .i_clk   (sys_clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (wr_data),
      .i_raddr ({r_front, rd_addr}),
      .o_rdata (w_ram_q)
   );

   assign wr_ready     = r_wr_ready;
   assign rd_data      = r_rd_hit ? w_ram_q : 8'h00;
   assign rd_len       = r_rd_len;
   assign rd_valid     = r_rd_valid;
   assign drop_count   = r_drop_cnt;
   assign err_oversize = r_err;

endmodule

// File: tb/tb_pkt_bank_scheduler.sv
// tb/tb_pkt_bank_scheduler.sv - scoreboard bench for pkt_bank_scheduler
module tb_pkt_bank_scheduler;

   localparam int AW = 11;

   logic          sys_clk = 1'b0;
   logic          sys_rstn = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          wr_valid = 1'b0;
   logic          wr_last = 1'b0;
   logic          frame_sync = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          wr_ready;
   logic [7:0]    rd_data;
   logic [15:0]   rd_len;
   logic          rd_valid;
   logic [15:0]   drop_count;
   logic          err_oversize;

   typedef struct {
      logic        rdy;
      logic        vld;
      logic [15:0] len;
      logic [15:0] drop;
      bit          use_data;
   } stat_t;

   stat_t       q_stat[$];
   string       q_stat_nm[$];
   logic [7:0]  q_rd[$];
   string       q_rd_nm[$];
   int          q_err[$];
   logic [7:0]  pkt[$];

   logic tb_stat_req = 1'b0;
   logic tb_rd_issue = 1'b0;
   logic tb_rd_pend  = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   byte_cnt = 0;
   int   last_byte = 0;

   stat_t      mon_st;
   string      mon_nm;
   logic [7:0] mon_rd;
   int         mon_err;

   always #5 sys_clk = ~sys_clk;

   pkt_bank_scheduler dut (
      .sys_clk      (sys_clk),
      .sys_rstn     (sys_rstn),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .wr_last      (wr_last),
      .wr_ready     (wr_ready),
      .frame_sync   (frame_sync),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .rd_len       (rd_len),
      .rd_valid     (rd_valid),
      .drop_count   (drop_count),
      .err_oversize (err_oversize)
   );

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event expected none", name);
   endtask

   always @(posedge sys_clk) begin
      tb_rd_pend <= tb_rd_issue;
      if (!sys_rstn) begin
         byte_cnt <= 0;
      end else if (wr_valid) begin
         last_byte <= byte_cnt + 1;
         byte_cnt  <= wr_last ? 0 : byte_cnt + 1;
      end
   end

   always @(negedge sys_clk) begin
      if (tb_rd_pend) begin
         if (q_rd.size() == 0) begin
            flag_fail("rd_unexpected");
         end else begin
            mon_rd = q_rd.pop_front();
            mon_nm = q_rd_nm.pop_front();
            cmp(mon_nm, {8'h00, rd_data}, {8'h00, mon_rd});
         end
      end
      if (tb_stat_req) begin
         if (q_stat.size() == 0) begin
            flag_fail("stat_unexpected");
         end else begin
            mon_st = q_stat.pop_front();
            mon_nm = q_stat_nm.pop_front();
            cmp({mon_nm, "_wr_ready"},   {15'h0, wr_ready}, {15'h0, mon_st.rdy});
            cmp({mon_nm, "_rd_valid"},   {15'h0, rd_valid}, {15'h0, mon_st.vld});
            cmp({mon_nm, "_rd_len"},     rd_len, mon_st.len);
            cmp({mon_nm, "_drop_count"}, drop_count, mon_st.drop);
            if (mon_st.use_data) begin
               cmp({mon_nm, "_rd_data"}, {8'h00, rd_data}, 16'h0000);
               cmp({mon_nm, "_err"}, {15'h0, err_oversize}, 16'h0000);
            end
         end
      end
      if (err_oversize) begin
         if (q_err.size() == 0) begin
            flag_fail("err_oversize_unexpected");
         end else begin
            mon_err = q_err.pop_front();
            cmp("err_oversize_byte", 16'(last_byte), 16'(mon_err));
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic mk_seq(input logic [7:0] base, input int n);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(base + 8'(i));
   endtask

   task automatic send(input int gap_at, input bit sync_last);
      for (int i = 0; i < pkt.size(); i++) begin
         if (i == gap_at) begin
            wr_valid = 1'b0;
            tick();
         end
         wr_data    = pkt[i];
         wr_valid   = 1'b1;
         wr_last    = (i == pkt.size() - 1);
         frame_sync = sync_last && (i == pkt.size() - 1);
         tick();
      end
      wr_valid   = 1'b0;
      wr_last    = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic sync();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
   endtask

   task automatic exp_stat(input logic rdy, input logic vld, input logic [15:0] len,
                           input logic [15:0] drop, input bit use_data, input string name);
      stat_t s;
      s.rdy = rdy; s.vld = vld; s.len = len; s.drop = drop; s.use_data = use_data;
      q_stat.push_back(s);
      q_stat_nm.push_back(name);
      tb_stat_req = 1'b1;
      tick();
      tb_stat_req = 1'b0;
   endtask

   task automatic rd(input int a, input logic [7:0] e, input string name);
      q_rd.push_back(e);
      q_rd_nm.push_back(name);
      rd_addr     = AW'(a);
      tb_rd_issue = 1'b1;
      tick();
      tb_rd_issue = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rstn = 1'b0;
      repeat (3) tick();
      exp_stat(0, 0, 16'd0, 16'd0, 1, "rst");
      sys_rstn = 1'b1;
      exp_stat(0, 0, 16'd0, 16'd0, 1, "rel_first");
      exp_stat(1, 0, 16'd0, 16'd0, 0, "rel_ready");

      pkt.delete();
      pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
      send(2, 0);
      sync();
      exp_stat(1, 1, 16'd4, 16'd0, 0, "t1");
      rd(2, 8'hBE, "t1_rd2");
      rd(0, 8'hDE, "t1_rd0");
      rd(3, 8'hEF, "t1_rd3");
      rd(4, 8'h00, "t1_rd4_len");

      mk_seq(8'h10, 10); send(-1, 0);
      mk_seq(8'h20, 10); send(-1, 0);
      sync();
      exp_stat(1, 1, 16'd10, 16'd1, 0, "t2");
      rd(0, 8'h20, "t2_rd0");
      rd(5, 8'h25, "t2_rd5");
      rd(9, 8'h29, "t2_rd9");
      rd(10, 8'h00, "t2_rd10_len");

      pkt.delete();
      for (int i = 0; i < 1501; i++) pkt.push_back(8'(i) ^ 8'h5A);
      q_err.push_back(1501);
      send(-1, 0);
      sync();
      exp_stat(1, 1, 16'd10, 16'd2, 0, "t3");
      rd(3, 8'h23, "t3_rd3");
      rd(1499, 8'h00, "t3_rd1499");

      mk_seq(8'hA0, 6); send(-1, 1);
      exp_stat(1, 1, 16'd10, 16'd2, 0, "t4_noswap");
      sync();
      exp_stat(1, 1, 16'd6, 16'd2, 0, "t4_swap");
      rd(5, 8'hA5, "t4_rd5");
      rd(0, 8'hA0, "t4_rd0");
      rd(6, 8'h00, "t4_rd6_len");

      mk_seq(8'h31, 3); send(-1, 0);
      sync();
      exp_stat(1, 1, 16'd3, 16'd2, 0, "t5_sync1");
      repeat (7) sync();
      exp_stat(1, 1, 16'd3, 16'd2, 0, "t5_sync8");
      sync();
      exp_stat(1, 0, 16'd3, 16'd2, 0, "t5_sync9");
      rd(0, 8'h00, "t5_rd_blanked");
      pkt.delete(); pkt.push_back(8'h77); pkt.push_back(8'h88);
      send(-1, 0);
      sync();
      exp_stat(1, 1, 16'd2, 16'd2, 0, "t5_restore");
      rd(1, 8'h88, "t5_rd1");

      for (int i = 0; i < 3; i++) begin
         wr_data  = 8'h50 + 8'(i);
         wr_valid = 1'b1;
         tick();
      end
      wr_valid = 1'b0;
      sys_rstn = 1'b0;
      exp_stat(0, 0, 16'd0, 16'd0, 1, "t6_rst");
      tick();
      sys_rstn = 1'b1;
      tick();
      sync();
      exp_stat(1, 0, 16'd0, 16'd0, 0, "t6_empty_sync");
      mk_seq(8'h01, 4); send(-1, 0);
      sync();
      exp_stat(1, 1, 16'd4, 16'd0, 0, "t6_after");
      rd(3, 8'h04, "t6_rd3");
      rd(0, 8'h01, "t6_rd0");

      for (int i = 0; i < 20 && q_rd.size() != 0; i++) tick();
      tick();
      cmp("drain_rd_queue",   16'(q_rd.size()),   16'd0);
      cmp("drain_stat_queue", 16'(q_stat.size()), 16'd0);
      cmp("drain_err_queue",  16'(q_err.size()),  16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
